// File: rtl/sccb_init_sequencer.sv
// rtl/sccb_init_sequencer.sv - walks a camera register-init table through an SCCB master
//
// Purpose: generates the SCCB bit clock and its mid-low pulse, fetches
// {sub_addr, data} entries from a synchronous ROM, issues one SCCB write per
// entry (optionally followed by a read-back and compare), honours delay
// entries and stops at the end marker or at the last table address.
//
// Ports:
//   XCLK, RST_N      clock, asynchronous active-low reset
//   init_req         pulse, starts a table walk when idle
//   init_busy        high while walking the table
//   init_done        sticky completion flag, cleared by an accepted init_req
//   err_cnt          read-back mismatch count, saturating at 255
//   tbl_addr         ROM address; tbl_data is valid one XCLK later
//   tbl_data         {sub_addr[15:8], data[7:0]}; FFFF = end, FFF0 = delay
//   sccb_start       master start, held until sccb_done
//   sccb_ip_addr     device ID with R/W bit
//   sccb_sub_addr    register address
//   sccb_data_in     write data
//   sccb_done        master done
//   sccb_data_out    master read data
//   SCCB_CLK         SCCB bit clock (low for the first half of each period)
//   SCCB_MID_PULSE   one-XCLK pulse in the middle of the SCCB_CLK low phase
module sccb_init_sequencer #(
  parameter int          CLK_DIV   = 100,
  parameter logic [7:0]  DEV_ID    = 8'h42,
  parameter int          TBL_AW    = 8,
  parameter bit          VERIFY    = 1'b1,
  parameter logic [23:0] DELAY_CYC = 24'd1_000_000
) (
  input  logic              XCLK,
  input  logic              RST_N,
  input  logic              init_req,
  output logic              init_busy,
  output logic              init_done,
  output logic [7:0]        err_cnt,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic              sccb_done,
  input  logic [7:0]        sccb_data_out,
  output logic              SCCB_CLK,
  output logic              SCCB_MID_PULSE
);

  localparam int               CNT_W    = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_DIV / 2);

  localparam logic [15:0]       ENT_END   = 16'hFFFF;
  localparam logic [15:0]       ENT_DELAY = 16'hFFF0;
  localparam logic [TBL_AW-1:0] ADDR_LAST = {TBL_AW{1'b1}};
  localparam logic [7:0]        RD_ID     = DEV_ID | 8'h01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WR_START,
    S_WR_WAIT,
    S_WR_REL,
    S_RD_START,
    S_RD_WAIT,
    S_RD_REL,
    S_CHECK,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // SCCB bit-clock divider. The clock and pulse registers are loaded from the
  // next count so they line up with cnt_q itself rather than lagging it.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sccb_clk_q;
  logic             mid_pulse_q;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge XCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      sccb_clk_q  <= 1'b1;
      mid_pulse_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sccb_clk_q  <= (cnt_d >= CNT_HALF);
      mid_pulse_q <= (cnt_d == CNT_MID);
    end
  end

  assign SCCB_CLK       = sccb_clk_q;
  assign SCCB_MID_PULSE = mid_pulse_q;

  // ---------------------------------------------------------------------------
  // Table-walk FSM
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        err_cnt_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic              start_q;
  logic [7:0]        ip_addr_q;
  logic [7:0]        sub_addr_q;
  logic [7:0]        data_in_q;
  logic [7:0]        rd_data_q;
  logic [23:0]       dly_q;

  always_ff @(posedge XCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= 8'd0;
      tbl_addr_q <= '0;
      start_q    <= 1'b0;
      ip_addr_q  <= DEV_ID;
      sub_addr_q <= 8'd0;
      data_in_q  <= 8'd0;
      rd_data_q  <= 8'd0;
      dly_q      <= 24'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init_req) begin
            tbl_addr_q <= '0;
            done_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        // tbl_addr_q is on the ROM bus this cycle; the entry arrives next cycle.
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (tbl_data == ENT_END) begin
            state_q <= S_DONE;
          end else if (tbl_data == ENT_DELAY) begin
            dly_q   <= DELAY_CYC;
            state_q <= S_DELAY;
          end else begin
            sub_addr_q <= tbl_data[15:8];
            data_in_q  <= tbl_data[7:0];
            ip_addr_q  <= DEV_ID;
            state_q    <= S_WR_START;
          end
        end
        S_WR_START: begin
          start_q <= 1'b1;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (sccb_done) begin
            start_q <= 1'b0;
            state_q <= S_WR_REL;
          end
        end
        // The master only drops done on a mid pulse with start low, so waiting
        // here guarantees start is never re-raised against a stale done.
        S_WR_REL: begin
          if (!sccb_done) begin
            state_q <= VERIFY ? S_RD_START : S_NEXT;
          end
        end
        S_RD_START: begin
          ip_addr_q <= RD_ID;
          start_q   <= 1'b1;
          state_q   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (sccb_done) begin
            rd_data_q <= sccb_data_out;
            start_q   <= 1'b0;
            state_q   <= S_RD_REL;
          end
        end
        S_RD_REL: begin
          if (!sccb_done) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((rd_data_q != data_in_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
          ip_addr_q <= DEV_ID;
          state_q   <= S_NEXT;
        end
        S_DELAY: begin
          if (dly_q == 24'd0) begin
            state_q <= S_NEXT;
          end else begin
            dly_q <= dly_q - 24'd1;
          end
        end
        // The last table slot is treated as an implicit end marker.
        S_NEXT: begin
          if (tbl_addr_q == ADDR_LAST) begin
            state_q <= S_DONE;
          end else begin
            tbl_addr_q <= tbl_addr_q + TBL_AW'(1);
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign init_busy     = busy_q;
  assign init_done     = done_q;
  assign err_cnt       = err_cnt_q;
  assign tbl_addr      = tbl_addr_q;
  assign sccb_start    = start_q;
  assign sccb_ip_addr  = ip_addr_q;
  assign sccb_sub_addr = sub_addr_q;
  assign sccb_data_in  = data_in_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb/tb_sccb_init_sequencer.sv - directed self-checking bench for sccb_init_sequencer
module tb_sccb_init_sequencer;

  logic XCLK  = 1'b0;
  logic RST_N = 1'b0;
  always #5 XCLK = ~XCLK;

  // index 0: VERIFY=0 instance, index 1: VERIFY=1 instance
  logic        init_req   [2];
  logic        init_busy  [2];
  logic        init_done  [2];
  logic [7:0]  err_cnt    [2];
  logic [3:0]  tbl_addr   [2];
  logic [15:0] tbl_data   [2];
  logic        sccb_start [2];
  logic [7:0]  ip         [2];
  logic [7:0]  sub        [2];
  logic [7:0]  din        [2];
  logic        m_done     [2];
  logic [7:0]  m_dout     [2];
  logic        sclk       [2];
  logic        mid        [2];

  sccb_init_sequencer #(
    .CLK_DIV(4), .DEV_ID(8'h42), .TBL_AW(4), .VERIFY(1'b0), .DELAY_CYC(24'd50)
  ) u_nv (
    .XCLK(XCLK), .RST_N(RST_N), .init_req(init_req[0]), .init_busy(init_busy[0]),
    .init_done(init_done[0]), .err_cnt(err_cnt[0]), .tbl_addr(tbl_addr[0]),
    .tbl_data(tbl_data[0]), .sccb_start(sccb_start[0]), .sccb_ip_addr(ip[0]),
    .sccb_sub_addr(sub[0]), .sccb_data_in(din[0]), .sccb_done(m_done[0]),
    .sccb_data_out(m_dout[0]), .SCCB_CLK(sclk[0]), .SCCB_MID_PULSE(mid[0])
  );

  sccb_init_sequencer #(
    .CLK_DIV(4), .DEV_ID(8'h42), .TBL_AW(4), .VERIFY(1'b1), .DELAY_CYC(24'd50)
  ) u_v (
    .XCLK(XCLK), .RST_N(RST_N), .init_req(init_req[1]), .init_busy(init_busy[1]),
    .init_done(init_done[1]), .err_cnt(err_cnt[1]), .tbl_addr(tbl_addr[1]),
    .tbl_data(tbl_data[1]), .sccb_start(sccb_start[1]), .sccb_ip_addr(ip[1]),
    .sccb_sub_addr(sub[1]), .sccb_data_in(din[1]), .sccb_done(m_done[1]),
    .sccb_data_out(m_dout[1]), .SCCB_CLK(sclk[1]), .SCCB_MID_PULSE(mid[1])
  );

  // ROM and camera/master models
  logic [15:0] rom    [2][16];
  logic [7:0]  mem    [2][256];
  logic [7:0]  mask   [2];
  logic        m_busy [2];
  logic [1:0]  m_lat  [2];

  int         n_wr [2];
  int         n_rd [2];
  int         n_done_rise [2];
  logic [7:0] wr_ip [2], wr_sub [2], wr_din [2], rd_ip [2];
  int         last_fall [2];
  int         gap [2];
  int         viol = 0;
  int         cyc = 0;
  logic       p_start [2], p_done [2], p_idone [2];
  logic [7:0] p_ip [2], p_sub [2], p_din [2];

  int n_chk = 0;
  int n_err = 0;

  always @(posedge XCLK) begin
    for (int i = 0; i < 2; i++) tbl_data[i] <= rom[i][tbl_addr[i]];
  end

  // Master: completes a transfer on the 3rd mid pulse after start, clears
  // done on a mid pulse once start is low. Reads return mem ^ mask.
  always @(posedge XCLK or negedge RST_N) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST_N) begin
        m_done[i] <= 1'b0;
        m_busy[i] <= 1'b0;
        m_lat[i]  <= 2'd0;
        m_dout[i] <= 8'd0;
      end else if (m_busy[i]) begin
        if (mid[i]) begin
          if (m_lat[i] == 2'd0) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            if (ip[i][0]) begin
              m_dout[i] <= mem[i][sub[i]] ^ mask[i];
              n_rd[i]   <= n_rd[i] + 1;
              rd_ip[i]  <= ip[i];
            end else begin
              mem[i][sub[i]] <= din[i];
              n_wr[i]   <= n_wr[i] + 1;
              wr_ip[i]  <= ip[i];
              wr_sub[i] <= sub[i];
              wr_din[i] <= din[i];
            end
          end else begin
            m_lat[i] <= m_lat[i] - 2'd1;
          end
        end
      end else if (m_done[i]) begin
        if (!sccb_start[i] && mid[i]) m_done[i] <= 1'b0;
      end else if (sccb_start[i]) begin
        m_busy[i] <= 1'b1;
        m_lat[i]  <= 2'd2;
      end
    end
  end

  // Protocol monitor: start rise against done, field stability, timing gaps
  always @(posedge XCLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      p_start[i] <= sccb_start[i];
      p_done[i]  <= m_done[i];
      p_idone[i] <= init_done[i];
      p_ip[i]    <= ip[i];
      p_sub[i]   <= sub[i];
      p_din[i]   <= din[i];
      if (sccb_start[i] && !p_start[i]) begin
        gap[i] <= cyc - last_fall[i];
        if (m_done[i]) viol <= viol + 1;
      end
      if (sccb_start[i] && p_start[i] &&
          (ip[i] != p_ip[i] || sub[i] != p_sub[i] || din[i] != p_din[i]))
        viol <= viol + 1;
      if (!m_done[i] && p_done[i]) last_fall[i] <= cyc;
      if (init_done[i] && !p_idone[i]) n_done_rise[i] <= n_done_rise[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic rom_fill(input int i, input logic [15:0] v);
    for (int a = 0; a < 16; a++) rom[i][a] = v;
  endtask

  task automatic pulse_req(input int i);
    @(negedge XCLK) init_req[i] = 1'b1;
    @(negedge XCLK) init_req[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int k;
    k = 0;
    while (!init_done[i] && k < 4000) begin
      @(negedge XCLK);
      k++;
    end
    check({tag, "_done"}, 32'(init_done[i]), 32'd1);
    check({tag, "_idle"}, 32'(init_busy[i]), 32'd0);
  endtask

  task automatic walk(input int i, input string tag);
    pulse_req(i);
    check({tag, "_busy"}, 32'(init_busy[i]), 32'd1);
    check({tag, "_clr"}, 32'(init_done[i]), 32'd0);
    wait_done(i, tag);
  endtask

  logic       prev_c;
  logic [7:0] pat_c, pat_m;
  int         k, base_wr, base_rise;

  initial begin
    for (int i = 0; i < 2; i++) begin
      init_req[i] = 1'b0;
      mask[i]     = 8'h00;
      rom_fill(i, 16'hFFFF);
    end
    repeat (3) @(negedge XCLK);

    // reset values, still inside reset
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(init_busy[i]), 32'd0);
      check("rst_done", 32'(init_done[i]), 32'd0);
      check("rst_err", 32'(err_cnt[i]), 32'd0);
      check("rst_addr", 32'(tbl_addr[i]), 32'd0);
      check("rst_start", 32'(sccb_start[i]), 32'd0);
      check("rst_ip", 32'(ip[i]), 32'h42);
      check("rst_sub", 32'(sub[i]), 32'd0);
      check("rst_din", 32'(din[i]), 32'd0);
      check("rst_sclk", 32'(sclk[i]), 32'd1);
      check("rst_mid", 32'(mid[i]), 32'd0);
    end
    RST_N = 1'b1;
    repeat (10) @(negedge XCLK);

    // divider: 4 low / 4 high, mid pulse two XCLK into the low phase
    prev_c = sclk[0];
    @(negedge XCLK);
    k = 0;
    while (!(prev_c && !sclk[0]) && k < 100) begin
      prev_c = sclk[0];
      @(negedge XCLK);
      k++;
    end
    for (int j = 0; j < 8; j++) begin
      pat_c[j] = sclk[0];
      pat_m[j] = mid[0];
      @(negedge XCLK);
    end
    check("sclk_pat", 32'(pat_c), 32'hF0);
    check("mid_pat", 32'(pat_m), 32'h04);

    // single write, no verify
    rom[0][0] = 16'h1280;
    walk(0, "t1");
    check("t1_nwr", n_wr[0], 1);
    check("t1_nrd", n_rd[0], 0);
    check("t1_ip", 32'(wr_ip[0]), 32'h42);
    check("t1_sub", 32'(wr_sub[0]), 32'h12);
    check("t1_din", 32'(wr_din[0]), 32'h80);
    check("t1_addr", 32'(tbl_addr[0]), 32'd1);

    // verify, matching read-back
    rom[1][0] = 16'h3A04;
    walk(1, "v0");
    check("v0_nwr", n_wr[1], 1);
    check("v0_nrd", n_rd[1], 1);
    check("v0_wip", 32'(wr_ip[1]), 32'h42);
    check("v0_rip", 32'(rd_ip[1]), 32'h43);
    check("v0_err", 32'(err_cnt[1]), 32'd0);
    check("v0_ipback", 32'(ip[1]), 32'h42);

    // verify, corrupted read-back returns 0x05
    mask[1] = 8'h01;
    walk(1, "v1");
    check("v1_nrd", n_rd[1], 2);
    check("v1_err", 32'(err_cnt[1]), 32'd1);

    // delay entry between two writes
    rom[0][1] = 16'hFFF0;
    rom[0][2] = 16'h1101;
    rom[0][3] = 16'hFFFF;
    base_wr = n_wr[0];
    walk(0, "dl");
    check("dl_nwr", n_wr[0] - base_wr, 2);
    check("dl_gap", 32'(gap[0] >= 50), 32'd1);
    check("dl_sub", 32'(wr_sub[0]), 32'h11);
    check("dl_din", 32'(wr_din[0]), 32'h01);
    check("dl_addr", 32'(tbl_addr[0]), 32'd3);

    // init_req while busy is ignored
    rom[1][1] = 16'h1101;
    rom[1][2] = 16'hFFFF;
    base_wr   = n_wr[1];
    base_rise = n_done_rise[1];
    pulse_req(1);
    k = 0;
    while (tbl_addr[1] != 4'd1 && k < 2000) begin
      @(negedge XCLK);
      k++;
    end
    check("bz_reach", 32'(tbl_addr[1]), 32'd1);
    pulse_req(1);
    wait_done(1, "bz");
    repeat (20) @(negedge XCLK);
    check("bz_err", 32'(err_cnt[1]), 32'd2);
    check("bz_addr", 32'(tbl_addr[1]), 32'd2);
    check("bz_nwr", n_wr[1] - base_wr, 2);
    check("bz_rise", n_done_rise[1] - base_rise, 1);

    // full table with no end marker stops at the last address
    for (int a = 0; a < 16; a++) rom[0][a] = {8'h20 + 8'(a), 8'h10 + 8'(a)};
    base_wr = n_wr[0];
    walk(0, "nw");
    repeat (50) @(negedge XCLK);
    check("nw_nwr", n_wr[0] - base_wr, 16);
    check("nw_addr", 32'(tbl_addr[0]), 32'd15);
    check("nw_sub", 32'(wr_sub[0]), 32'h2F);
    check("nw_din", 32'(wr_din[0]), 32'h1F);

    // asynchronous reset during the second entry's read
    rom[1][0] = 16'h3A04;
    rom[1][1] = 16'h3B05;
    rom[1][2] = 16'hFFFF;
    mask[1]   = 8'h01;
    pulse_req(1);
    k = 0;
    while (!(sccb_start[1] && ip[1] == 8'h43 && sub[1] == 8'h3B) && k < 2000) begin
      @(negedge XCLK);
      k++;
    end
    check("rs_reach", 32'(sccb_start[1] && ip[1] == 8'h43), 32'd1);
    check("rs_pre_err", 32'(err_cnt[1]), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("rs_start", 32'(sccb_start[1]), 32'd0);
    check("rs_busy", 32'(init_busy[1]), 32'd0);
    check("rs_err", 32'(err_cnt[1]), 32'd0);
    check("rs_ip", 32'(ip[1]), 32'h42);
    check("rs_addr", 32'(tbl_addr[1]), 32'd0);
    @(negedge XCLK) RST_N = 1'b1;
    mask[1] = 8'h00;
    repeat (5) @(negedge XCLK);
    check("rs_stay", 32'(init_busy[1]), 32'd0);
    base_wr = n_wr[1];
    pulse_req(1);
    k = 0;
    while (!sccb_start[1] && k < 2000) begin
      @(negedge XCLK);
      k++;
    end
    check("rs_first_addr", 32'(tbl_addr[1]), 32'd0);
    check("rs_first_sub", 32'(sub[1]), 32'h3A);
    wait_done(1, "rs");
    check("rs_nwr", n_wr[1] - base_wr, 2);
    check("rs_end_err", 32'(err_cnt[1]), 32'd0);

    check("proto_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
